// File: rtl/fdtd_stream_engine.sv
// Streaming 1-D FDTD Hy/Ez update core: 3-stage datapath feeding an output FIFO.
// Define FDTD_SRC_INJECT_EN to add src_term_i at element src_idx_i.
module fdtd_stream_engine #(
    parameter int DATA_W   = 32,
    parameter int FRAC_W   = 16,
    parameter int IDX_W    = 15,
    parameter int OQ_DEPTH = 4
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              start_i,
    input  logic              mode_i,
    input  logic [IDX_W-1:0]  len_i,
    input  logic [DATA_W-1:0] coef_self_i,
    input  logic [DATA_W-1:0] coef_curl_i,
    input  logic [IDX_W-1:0]  src_idx_i,
    input  logic [DATA_W-1:0] src_term_i,
    input  logic              s_valid_i,
    output logic              s_ready_o,
    input  logic [DATA_W-1:0] s_self_i,
    input  logic [DATA_W-1:0] s_nbr_i,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic [DATA_W-1:0] m_data_o,
    output logic [IDX_W-1:0]  m_idx_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              sat_err_o
);
    localparam int AW = $clog2(OQ_DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = 2 * DATA_W + 1;
    localparam int SW = PW + 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    logic [1:0]               state;
    logic                     mode_r;
    logic [IDX_W-1:0]         len_r;
    logic [IDX_W-1:0]         acc_cnt;
    logic signed [DATA_W-1:0] cs_r;
    logic signed [DATA_W-1:0] cc_r;
    logic signed [DATA_W-1:0] prev_self;
    logic signed [DATA_W-1:0] prev_nbr;

    logic                     v1;
    logic signed [DATA_W:0]   d1;
    logic signed [DATA_W-1:0] self1;
    logic [IDX_W-1:0]         idx1;
    logic                     v2;
    logic signed [PW-1:0]     ps2;
    logic signed [PW-1:0]     pc2;
    logic [IDX_W-1:0]         idx2;

    logic [DATA_W-1:0]        q_data [OQ_DEPTH];
    logic [IDX_W-1:0]         q_idx  [OQ_DEPTH];
    logic [AW-1:0]            wr_ptr;
    logic [AW-1:0]            rd_ptr;
    logic [CW-1:0]            q_cnt;

    logic [CW-1:0]            free_cnt;
    logic [CW-1:0]            inflight;
    logic                     room;
    logic                     accept;
    logic                     flush_go;
    logic                     tok_v;
    logic signed [DATA_W-1:0] tok_nbr;
    logic signed [DATA_W-1:0] tok_self;
    logic signed [DATA_W:0]   tok_diff;
    logic [IDX_W-1:0]         tok_idx;
    logic signed [PW-1:0]     prod_s;
    logic signed [PW-1:0]     prod_c;
    logic signed [SW-1:0]     sum;
    logic [SW-DATA_W:0]       upper;
    logic                     ovf;
    logic [DATA_W-1:0]        res;
    logic                     pop;

    // Reserve a queue slot for every token already in S1/S2 so nothing is dropped.
    assign free_cnt = CW'(OQ_DEPTH) - q_cnt;
    assign inflight = CW'(v1) + CW'(v2);
    assign room     = free_cnt > inflight;

    assign s_ready_o = (state == RUN) && (acc_cnt != len_r) && room;
    assign accept    = s_valid_i && s_ready_o;
    assign flush_go  = (state == FLUSH) && room;

    // Hy element 0 only primes prev_*; the flush token supplies nbr[len] = 0.
    assign tok_v    = (accept && (mode_r || acc_cnt != '0)) || flush_go;
    assign tok_nbr  = flush_go ? '0 : s_nbr_i;
    assign tok_self = mode_r ? s_self_i : prev_self;
    assign tok_diff = (DATA_W+1)'(tok_nbr) - (DATA_W+1)'(prev_nbr);
    assign tok_idx  = flush_go ? len_r - 1'b1
                    : (mode_r ? acc_cnt : acc_cnt - 1'b1);

    assign prod_s = (PW'(cs_r) * PW'(self1)) >>> FRAC_W;
    assign prod_c = (PW'(cc_r) * PW'(d1)) >>> FRAC_W;

`ifdef FDTD_SRC_INJECT_EN
    logic [IDX_W-1:0]         src_idx_r;
    logic signed [DATA_W-1:0] src_term_r;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            src_idx_r  <= '0;
            src_term_r <= '0;
        end else if (state == IDLE && start_i) begin
            src_idx_r  <= src_idx_i;
            src_term_r <= src_term_i;
        end
    end

    assign sum = SW'(ps2) + SW'(pc2)
               + ((idx2 == src_idx_r) ? SW'(src_term_r) : '0);
`else
    logic unused_src;
    assign unused_src = ^{src_idx_i, src_term_i};
    assign sum = SW'(ps2) + SW'(pc2);
`endif

    // Result fits iff all bits above the DATA_W sign bit agree with it.
    assign upper = sum[SW-1:DATA_W-1];
    assign ovf   = !((&upper) || !(|upper));
    assign res   = !ovf ? sum[DATA_W-1:0]
                 : (sum[SW-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                              : {1'b0, {(DATA_W-1){1'b1}}});

    assign m_valid_o = q_cnt != '0;
    assign pop       = m_valid_o && m_ready_i;
    assign m_data_o  = m_valid_o ? q_data[rd_ptr] : '0;
    assign m_idx_o   = m_valid_o ? q_idx[rd_ptr] : '0;
    assign busy_o    = state != IDLE;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state     <= IDLE;
            mode_r    <= 1'b0;
            len_r     <= '0;
            acc_cnt   <= '0;
            cs_r      <= '0;
            cc_r      <= '0;
            prev_self <= '0;
            prev_nbr  <= '0;
            done_o    <= 1'b0;
            sat_err_o <= 1'b0;
            v1        <= 1'b0;
            d1        <= '0;
            self1     <= '0;
            idx1      <= '0;
            v2        <= 1'b0;
            ps2       <= '0;
            pc2       <= '0;
            idx2      <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            q_cnt     <= '0;
        end else begin
            done_o <= 1'b0;
            unique case (state)
                IDLE: if (start_i) begin
                    mode_r    <= mode_i;
                    len_r     <= len_i;
                    cs_r      <= coef_self_i;
                    cc_r      <= coef_curl_i;
                    acc_cnt   <= '0;
                    prev_self <= '0;
                    prev_nbr  <= '0;
                    sat_err_o <= 1'b0;
                    if (len_i == '0) done_o <= 1'b1;
                    else state <= RUN;
                end
                RUN: if (accept && acc_cnt == len_r - 1'b1)
                    state <= mode_r ? DRAIN : FLUSH;
                FLUSH: if (flush_go) state <= DRAIN;
                DRAIN: if (!v1 && !v2 && q_cnt == '0) begin
                    done_o <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (accept) begin
                acc_cnt   <= acc_cnt + 1'b1;
                prev_self <= s_self_i;
                prev_nbr  <= s_nbr_i;
            end
            v1 <= tok_v;
            if (tok_v) begin
                d1    <= tok_diff;
                self1 <= tok_self;
                idx1  <= tok_idx;
            end
            v2 <= v1;
            if (v1) begin
                ps2  <= prod_s;
                pc2  <= prod_c;
                idx2 <= idx1;
            end
            if (v2) begin
                q_data[wr_ptr] <= res;
                q_idx[wr_ptr]  <= idx2;
                wr_ptr         <= wr_ptr + 1'b1;
                if (ovf) sat_err_o <= 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (v2 && !pop) q_cnt <= q_cnt + 1'b1;
            else if (!v2 && pop) q_cnt <= q_cnt - 1'b1;
        end
    end
endmodule

// File: doc/fdtd_stream_engine.md
Name: fdtd_stream_engine

Overview:
- Parametrised streaming 1-D FDTD update core. It is the next-generation replacement for the fixed 32-bit buffered Hy/Ez calculator inside the FDTD accelerator.
- It consumes a valid/ready stream of (self, neighbour) field samples from the memory controller and returns updated field words with their indices.
- Data width, fraction width, index width and output queue depth are parametrised. One instance handles both Hy and Ez update modes.
- It adds saturation detection, the Hy-mode one-sample lag with boundary flush, and optional source injection.

Parameters:
- DATA_W, 32: field/coefficient width, signed fixed point.
- FRAC_W, 16: fractional bits (1.0 = 2^FRAC_W).
- IDX_W, 15: element index / length width.
- OQ_DEPTH, 4: output queue entries, power of 2, >= 4.

Ports:
- ACLK  in  1  clock
- ARESET  in  1  synchronous active-high reset
- start_i  in  1  pulse; latches mode/len/coefs, begins a pass
- mode_i  in  1  0 = Hy update, 1 = Ez update
- len_i  in  IDX_W  element count
- coef_self_i  in  DATA_W  chyh or ceze
- coef_curl_i  in  DATA_W  chyez or cezhy (sign included by software)
- src_idx_i  in  IDX_W  source element index
- src_term_i  in  DATA_W  precomputed cezj*Jz
- s_valid_i  in  1  input sample valid
- s_ready_o  out  1  input ready
- s_self_i  in  DATA_W  old value of the field being updated
- s_nbr_i  in  DATA_W  other field at the same index
- m_valid_o  out  1  result valid
- m_ready_i  in  1  result accepted
- m_data_o  out  DATA_W  updated field
- m_idx_o  out  IDX_W  element index of m_data_o
- busy_o  out  1  pass in progress
- done_o  out  1  one-cycle pulse at pass end
- sat_err_o  out  1  sticky saturation flag, cleared by start_i

Behaviour:
- Reset values: s_ready_o, m_valid_o, busy_o, done_o, sat_err_o = 0; m_data_o, m_idx_o = 0; queue empty; counters and prev registers = 0.
- FSM states: IDLE, RUN, FLUSH, DRAIN.
  - IDLE + start_i, len=0: done_o pulses next cycle, no outputs.
  - IDLE + start_i, len>0: go to RUN, busy_o=1, prev registers cleared.
  - start_i while busy is ignored.
- s_ready_o = RUN & not all len accepted & queue free slots > in-flight count. No input is ever dropped.
- Ez mode: element k emits Ez'[k] = cs*self[k] + cc*(nbr[k] - nbr[k-1]), with nbr[-1] = 0.
- Hy mode: accepting element k (k>=1) emits Hy'[k-1] = cs*self[k-1] + cc*(nbr[k] - nbr[k-1]). self[k-1] is held in a register.
  - Element 0 only primes the registers.
  - After the last accept, FLUSH injects one internal token for Hy'[len-1] with nbr[len] = 0.
  - Ez mode skips FLUSH.
- Pipeline, 3 stages:
  - S1: difference, DATA_W+1 bits.
  - S2: both products, full 2*DATA_W+1 width, arithmetic shift right by FRAC_W (truncate toward -inf).
  - S3: sum (+ source term), saturate to DATA_W, push to queue.
- Latency: accept (or flush token) to m_valid_o = 3 cycles when the queue is empty and m_ready_i = 1.
- Saturation: clamp to 0x7FF..F / 0x800..0 and set sat_err_o. It stays set until the next start_i or reset.
- Output queue: FIFO, OQ_DEPTH entries. m_valid_o = not empty. Data moves on m_valid_o & m_ready_i. Indices are strictly increasing 0..len-1.
- DRAIN: entered after the last token enters S1. Wait for pipeline and queue empty plus the final handshake, then done_o pulses for 1 cycle and the FSM returns to IDLE with busy_o=0.
- ARESET mid-pass aborts immediately: queue flushed, no done_o.

Optional Feature:
- Macro: FDTD_SRC_INJECT_EN.
- Defined: at element index == src_idx_i (latched at start), S3 adds src_term_i before saturation.
- Undefined: src_idx_i and src_term_i are ignored and the adder is absent.

Test Plan (FRAC_W=16, 1.0=0x10000, cs=0x10000, cc=0x8000 unless stated):
- Ez mode, len=3, self=[0x10000,0,0], nbr=[0x20000,0x20000,0] -> out idx0..2 = 0x00020000, 0x00000000, 0xFFFF0000; done_o once; sat_err_o=0.
- Hy mode, len=2, self=[0x10000,0x10000], nbr=[0,0x20000] -> out idx0 = 0x00020000 (after 2nd accept), idx1 = 0x00000000 (flush); exactly 2 outputs.
- Ez mode, len=1, cc=0x10000, self=0x7FFF0000, nbr=0x20000 -> out 0x7FFFFFFF, sat_err_o=1, cleared by next start_i.
- Ez mode, len=8, m_ready_i held 0 for 10 cycles mid-pass -> s_ready_o drops, no loss, indices 0..7 in order, values match the model.
- FDTD_SRC_INJECT_EN, Ez, len=3, all self/nbr=0, src_idx=1, src_term=0x10000 -> outputs 0, 0x10000, 0.
- len=0 -> done_o pulses 1 cycle after start_i, no m_valid_o. ARESET during RUN -> all outputs at reset values, no done_o.
